// File: rtl/popcount_xs3_seq.sv
// popcount_xs3_seq: counts set bits of a WIDTH-bit word BPC bits per clock,
// result as BCD-derived excess-3 digits plus binary count.
// Optional segment outputs (HEX) when POPCOUNT_XS3_SEG_OUT_EN is defined.
module popcount_xs3_seq #(
    parameter int WIDTH = 16,
    parameter int BPC   = 1,
    parameter int NDIG  = 2
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         start,
    input  logic [WIDTH-1:0]             din,
    output logic                         busy,
    output logic                         done,
    output logic [4*NDIG-1:0]            xs3,
    output logic [$clog2(WIDTH+1)-1:0]   count
`ifdef POPCOUNT_XS3_SEG_OUT_EN
    ,
    output logic [7*NDIG-1:0]            HEX
`endif
);

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int CW = $clog2(WIDTH+1);
    localparam int PW = $clog2(BPC+1);
    localparam int N  = (BPC > 0) ? WIDTH / BPC : 1;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = 4 * NDIG;

    generate
        if (BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0 ||
            NDIG < 1 || pow10(NDIG) <= longint'(WIDTH)) begin : g_bad_cfg
            $error("popcount_xs3_seq: illegal WIDTH/BPC/NDIG combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Binary value (at most BPC) to packed BCD digits, double-dabble style.
    function automatic logic [DW-1:0] bin2bcd(input logic [PW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            for (int d = 0; d < NDIG; d++) begin
                if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
            end
            r = {r[DW-2:0], b[i]};
        end
        return r;
    endfunction

    // Decimal add: per-digit binary add, +6 correction, carry to next digit.
    function automatic logic [DW-1:0] bcd_add(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [DW-1:0] r;
        logic          c;
        logic [4:0]    s;
        r = '0;
        c = 1'b0;
        for (int d = 0; d < NDIG; d++) begin
            s = {1'b0, a[4*d +: 4]} + {1'b0, b[4*d +: 4]} + {4'b0000, c};
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*d +: 4] = s[3:0];
        end
        return r;
    endfunction

`ifdef POPCOUNT_XS3_SEG_OUT_EN
    // BCD digit to active-low {g..a}; codes above 9 blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = ~7'h3F;
            4'd1:    s = ~7'h06;
            4'd2:    s = ~7'h5B;
            4'd3:    s = ~7'h4F;
            4'd4:    s = ~7'h66;
            4'd5:    s = ~7'h6D;
            4'd6:    s = ~7'h7D;
            4'd7:    s = ~7'h07;
            4'd8:    s = ~7'h7F;
            4'd9:    s = ~7'h67;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [7*NDIG-1:0] hex_q, hex_d;
`endif

    state_t          state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic [CW-1:0]   bin_q, bin_d;
    logic [SW-1:0]   step_q, step_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   xs3_q, xs3_d;
    logic            done_q, done_d;
    logic [PW-1:0]   pc;

    // Popcount of the bits examined this SCAN cycle.
    always_comb begin
        pc = '0;
        for (int i = 0; i < BPC; i++) pc = pc + PW'(sr_q[i]);
    end

    // Next-state and datapath updates; results only change in FINISH.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        step_d  = step_q;
        count_d = count_q;
        xs3_d   = xs3_q;
        done_d  = 1'b0;
`ifdef POPCOUNT_XS3_SEG_OUT_EN
        hex_d   = hex_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = din;
                    bcd_d   = '0;
                    bin_d   = '0;
                    step_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                bcd_d  = bcd_add(bcd_q, bin2bcd(pc));
                bin_d  = bin_q + CW'(pc);
                sr_d   = sr_q >> BPC;
                step_d = step_q + 1'b1;
                if (step_q == SW'(N - 1)) state_d = FINISH;
            end
            FINISH: begin
                count_d = bin_q;
                for (int d = 0; d < NDIG; d++) begin
                    xs3_d[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
`ifdef POPCOUNT_XS3_SEG_OUT_EN
                    hex_d[7*d +: 7] = seg7(bcd_q[4*d +: 4]);
`endif
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            step_q  <= '0;
            count_q <= '0;
            xs3_q   <= {NDIG{4'h3}};
            done_q  <= 1'b0;
`ifdef POPCOUNT_XS3_SEG_OUT_EN
            hex_q   <= {NDIG{~7'h3F}};
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            step_q  <= step_d;
            count_q <= count_d;
            xs3_q   <= xs3_d;
            done_q  <= done_d;
`ifdef POPCOUNT_XS3_SEG_OUT_EN
            hex_q   <= hex_d;
`endif
        end
    end

    assign busy  = (state_q == SCAN);
    assign done  = done_q;
    assign xs3   = xs3_q;
    assign count = count_q;
`ifdef POPCOUNT_XS3_SEG_OUT_EN
    assign HEX   = hex_q;
`endif

endmodule

// File: tb/tb_popcount_xs3_seq.sv
// Directed bench for popcount_xs3_seq: BPC=1, BPC=4 and BPC=16 instances.
// Set POPCOUNT_XS3_SEG_OUT_EN to also check the HEX outputs.
module tb_popcount_xs3_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s1, s4, s16;
    logic [15:0] d1, d4, d16;
    logic        b1, b4, b16;
    logic        dn1, dn4, dn16;
    logic [7:0]  x1, x4, x16;
    logic [4:0]  c1, c4, c16;
`ifdef POPCOUNT_XS3_SEG_OUT_EN
    logic [13:0] h1, h4, h16;
`endif

    int tests = 0;
    int fails = 0;

    popcount_xs3_seq #(.WIDTH(16), .BPC(1), .NDIG(2)) u_dut1 (
        .CLOCK_50(clk), .reset(rst), .start(s1), .din(d1),
        .busy(b1), .done(dn1), .xs3(x1), .count(c1)
`ifdef POPCOUNT_XS3_SEG_OUT_EN
        , .HEX(h1)
`endif
    );

    popcount_xs3_seq #(.WIDTH(16), .BPC(4), .NDIG(2)) u_dut4 (
        .CLOCK_50(clk), .reset(rst), .start(s4), .din(d4),
        .busy(b4), .done(dn4), .xs3(x4), .count(c4)
`ifdef POPCOUNT_XS3_SEG_OUT_EN
        , .HEX(h4)
`endif
    );

    popcount_xs3_seq #(.WIDTH(16), .BPC(16), .NDIG(2)) u_dut16 (
        .CLOCK_50(clk), .reset(rst), .start(s16), .din(d16),
        .busy(b16), .done(dn16), .xs3(x16), .count(c16)
`ifdef POPCOUNT_XS3_SEG_OUT_EN
        , .HEX(h16)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic busy_of(input int w);
        case (w)
            0:       return b1;
            1:       return b4;
            default: return b16;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            0:       return dn1;
            1:       return dn4;
            default: return dn16;
        endcase
    endfunction

    // Drive start/din of one instance and pass the accepting edge.
    task automatic accept(input int w, input logic [15:0] d, input bit hold);
        case (w)
            0:       begin s1 = 1'b1;  d1 = d;  end
            1:       begin s4 = 1'b1;  d4 = d;  end
            default: begin s16 = 1'b1; d16 = d; end
        endcase
        tick();
        if (!hold) begin
            s1 = 1'b0;
            s4 = 1'b0;
            s16 = 1'b0;
        end
    endtask

    // Edges until done is seen (capped at 100); busy samples along the way.
    task automatic wait_done(input int w, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (lat < 100) begin
            tick();
            lat++;
            if (busy_of(w)) bc++;
            if (done_of(w)) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (b1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy got %b want 0", b1);
        end
        tests++;
        if (dn1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_done got %b want 0", dn1);
        end
        tests++;
        if (x1 !== 8'h33) begin
            fails++;
            $display("FAIL reset_xs3 got %h want 33", x1);
        end
        tests++;
        if (c1 !== 5'd0) begin
            fails++;
            $display("FAIL reset_count got %0d want 0", c1);
        end
        tests++;
        if (x4 !== 8'h33 || x16 !== 8'h33) begin
            fails++;
            $display("FAIL reset_xs3_bpc got %h/%h want 33/33", x4, x16);
        end
`ifdef POPCOUNT_XS3_SEG_OUT_EN
        tests++;
        if (h1 !== {~7'h3F, ~7'h3F}) begin
            fails++;
            $display("FAIL reset_hex got %h want %h", h1, {~7'h3F, ~7'h3F});
        end
`endif
    endtask

    task automatic test_zero();
        int lat, bc, b0;
        accept(0, 16'h0000, 1'b0);
        b0 = int'(b1);
        wait_done(0, lat, bc);
        tests++;
        if (lat !== 17) begin
            fails++;
            $display("FAIL zero_latency got %0d want 17", lat);
        end
        tests++;
        if (bc + b0 !== 16) begin
            fails++;
            $display("FAIL zero_busy_cycles got %0d want 16", bc + b0);
        end
        tests++;
        if (x1 !== 8'h33 || c1 !== 5'd0) begin
            fails++;
            $display("FAIL zero_result got %h/%0d want 33/0", x1, c1);
        end
        tests++;
        if (b1 !== 1'b0) begin
            fails++;
            $display("FAIL zero_busy_at_done got %b want 0", b1);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        accept(0, 16'hFFFF, 1'b1);
        wait_done(0, lat, bc);
        tests++;
        if (x1 !== 8'h49 || c1 !== 5'd16) begin
            fails++;
            $display("FAIL ones_result got %h/%0d want 49/16", x1, c1);
        end
`ifdef POPCOUNT_XS3_SEG_OUT_EN
        tests++;
        if (h1 !== {~7'h06, ~7'h7D}) begin
            fails++;
            $display("FAIL ones_hex got %h want %h", h1, {~7'h06, ~7'h7D});
        end
`endif
        d1 = 16'h00FF;
        wait_done(0, lat, bc);
        s1 = 1'b0;
        tests++;
        if (lat !== 18) begin
            fails++;
            $display("FAIL b2b_spacing got %0d want 18", lat);
        end
        tests++;
        if (x1 !== 8'h3B || c1 !== 5'd8) begin
            fails++;
            $display("FAIL b2b_result got %h/%0d want 3B/8", x1, c1);
        end
    endtask

    task automatic test_bpc();
        int lat, bc;
        accept(1, 16'hF0F1, 1'b0);
        wait_done(1, lat, bc);
        tests++;
        if (lat !== 5) begin
            fails++;
            $display("FAIL bpc4_latency got %0d want 5", lat);
        end
        tests++;
        if (x4 !== 8'h3C || c4 !== 5'd9) begin
            fails++;
            $display("FAIL bpc4_result got %h/%0d want 3C/9", x4, c4);
        end
        accept(2, 16'hF0F1, 1'b0);
        wait_done(2, lat, bc);
        tests++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL bpc16_latency got %0d want 2", lat);
        end
        tests++;
        if (x16 !== 8'h3C || c16 !== 5'd9) begin
            fails++;
            $display("FAIL bpc16_result got %h/%0d want 3C/9", x16, c16);
        end
        accept(2, 16'hFFFF, 1'b0);
        wait_done(2, lat, bc);
        tests++;
        if (x16 !== 8'h49 || c16 !== 5'd16) begin
            fails++;
            $display("FAIL bpc16_ones got %h/%0d want 49/16", x16, c16);
        end
    endtask

    task automatic test_ignore_start();
        int nd;
        nd = 0;
        accept(0, 16'h000F, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        s1 = 1'b1;
        d1 = 16'hFFFF;
        tick();
        s1 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (dn1) nd++;
        end
        tests++;
        if (nd !== 1) begin
            fails++;
            $display("FAIL ignore_done_pulses got %0d want 1", nd);
        end
        tests++;
        if (x1 !== 8'h37 || c1 !== 5'd4) begin
            fails++;
            $display("FAIL ignore_result got %h/%0d want 37/4", x1, c1);
        end
    endtask

    task automatic test_abort();
        int nd, lat, bc;
        nd = 0;
        accept(0, 16'hFFFF, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (b1 !== 1'b0 || dn1 !== 1'b0) begin
            fails++;
            $display("FAIL abort_flags got busy=%b done=%b want 0/0", b1, dn1);
        end
        tests++;
        if (x1 !== 8'h33 || c1 !== 5'd0) begin
            fails++;
            $display("FAIL abort_result got %h/%0d want 33/0", x1, c1);
        end
        for (int i = 0; i < 25; i++) begin
            tick();
            if (dn1) nd++;
        end
        tests++;
        if (nd !== 0) begin
            fails++;
            $display("FAIL abort_no_done got %0d want 0", nd);
        end
        accept(0, 16'h0001, 1'b0);
        wait_done(0, lat, bc);
        tests++;
        if (x1 !== 8'h34 || c1 !== 5'd1) begin
            fails++;
            $display("FAIL abort_restart got %h/%0d want 34/1", x1, c1);
        end
    endtask

    initial begin
        rst = 1'b1;
        s1 = 1'b0;
        s4 = 1'b0;
        s16 = 1'b0;
        d1 = '0;
        d4 = '0;
        d16 = '0;
        test_reset();
        test_zero();
        test_back_to_back();
        test_bpc();
        test_ignore_start();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
